// File: rtl/tc_pkg.sv
// Shared definitions for the partial-sum drain: FSM state encodings and
// sizing helpers used by both the controller and the top level.
package tc_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    function automatic int beat_count(input int m, input int n, input int lanes);
        return (m * n) / lanes;
    endfunction

    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/tc_drain_ctrl.sv
// Drain sequencer: FSM plus row/col/beat counters. All handshake outputs
// are registered from the next-state decode so they reset cleanly to 0.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | waiting for start
//   ST_REQ    | mat_req high, waiting for mat_valid to capture the matrix
//   ST_STREAM | presenting beats, advancing on o_ready
//   ST_DONE   | one-cycle done pulse, then back to idle
module tc_drain_ctrl
    import tc_pkg::*;
#(
    parameter int M      = 16,
    parameter int N      = 16,
    parameter int DW_POS = 4,
    parameter int LANES  = 4,
    parameter int BW     = idx_width(beat_count(M, N, LANES))
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mat_valid,
    input  logic              o_ready,
    output logic              mat_req,
    output logic              o_valid,
    output logic              o_last,
    output logic              busy,
    output logic              done,
    output logic [DW_POS-1:0] row,
    output logic [DW_POS-1:0] col,
    output logic [BW-1:0]     beat_nxt,
    output logic              capture,
    output logic              advance
);

    localparam logic [DW_POS-1:0] ROW_LAST = DW_POS'(M - 1);
    localparam logic [DW_POS-1:0] COL_LAST = DW_POS'(N - LANES);
    localparam logic [DW_POS-1:0] COL_STEP = DW_POS'(LANES);
    localparam logic [DW_POS-1:0] ROW_STEP = DW_POS'(1);
    localparam logic [BW-1:0]     BEAT_STEP = BW'(1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [DW_POS-1:0] row_nxt;
    logic [DW_POS-1:0] col_nxt;
    logic [BW-1:0]     beat;
    logic              at_last;

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        col_nxt   = col;
        beat_nxt  = beat;
        capture   = 1'b0;
        advance   = 1'b0;
        at_last   = (row == ROW_LAST) && (col == COL_LAST);
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (mat_valid) begin
                    capture   = 1'b1;
                    row_nxt   = '0;
                    col_nxt   = '0;
                    beat_nxt  = '0;
                    state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // Counters freeze on the final beat rather than wrapping.
                if (o_ready) begin
                    if (at_last) begin
                        state_nxt = ST_DONE;
                    end else begin
                        advance  = 1'b1;
                        beat_nxt = beat + BEAT_STEP;
                        if (col == COL_LAST) begin
                            col_nxt = '0;
                            row_nxt = row + ROW_STEP;
                        end else begin
                            col_nxt = col + COL_STEP;
                        end
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            row     <= '0;
            col     <= '0;
            beat    <= '0;
            mat_req <= 1'b0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            row     <= row_nxt;
            col     <= col_nxt;
            beat    <= beat_nxt;
            mat_req <= (state_nxt == ST_REQ);
            o_valid <= (state_nxt == ST_STREAM);
            o_last  <= (state_nxt == ST_STREAM) && (row_nxt == ROW_LAST) && (col_nxt == COL_LAST);
            busy    <= (state_nxt != ST_IDLE);
            done    <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: rtl/tc_psum_drain.sv
// Snapshots the accumulator's flat result matrix in one cycle and streams
// it out row-major, LANES elements per beat, over valid/ready.
module tc_psum_drain
    import tc_pkg::*;
#(
    parameter int M       = 16,
    parameter int N       = 16,
    parameter int DW_DATA = 32,
    parameter int DW_POS  = 4,
    parameter int LANES   = 4,
    parameter int NUM_MAT = M * N,
    parameter int DW_MAT  = NUM_MAT * DW_DATA
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     mat_req,
    input  logic                     mat_valid,
    input  logic [DW_MAT-1:0]        mat_in,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [LANES*DW_DATA-1:0] o_data,
    output logic [DW_POS-1:0]        o_row,
    output logic [DW_POS-1:0]        o_col,
    output logic                     o_last,
    output logic                     busy,
    output logic                     done
);

    localparam int LW        = LANES * DW_DATA;
    localparam int NUM_BEATS = beat_count(M, N, LANES);
    localparam int BW        = idx_width(NUM_BEATS);

    if ((N % LANES) != 0) begin : g_bad_lanes
        $error("tc_psum_drain: N must be a multiple of LANES");
    end
    if ((M > (1 << DW_POS)) || (N > (1 << DW_POS))) begin : g_bad_pos
        $error("tc_psum_drain: M and N must not exceed 2**DW_POS");
    end

    logic [DW_MAT-1:0] mat_buf;
    logic [BW-1:0]     beat_nxt;
    logic              capture;
    logic              advance;

    tc_drain_ctrl #(
        .M      (M),
        .N      (N),
        .DW_POS (DW_POS),
        .LANES  (LANES),
        .BW     (BW)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mat_valid (mat_valid),
        .o_ready   (o_ready),
        .mat_req   (mat_req),
        .o_valid   (o_valid),
        .o_last    (o_last),
        .busy      (busy),
        .done      (done),
        .row       (o_row),
        .col       (o_col),
        .beat_nxt  (beat_nxt),
        .capture   (capture),
        .advance   (advance)
    );

    // Row-major with N % LANES == 0 means element (row, col) of a beat sits at
    // flat index beat*LANES, so the (row, col) mux collapses to a beat index.
    // o_data is loaded one cycle ahead so it comes straight from a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mat_buf <= '0;
            o_data  <= '0;
        end else if (capture) begin
            mat_buf <= mat_in;
            o_data  <= mat_in[LW-1:0];
        end else if (advance) begin
            o_data  <= mat_buf[int'(beat_nxt) * LW +: LW];
        end
    end

endmodule

// File: tb/tb_tc_psum_drain.sv
// Scoreboard bench for tc_psum_drain: a 4x4/LANES=2 instance for directed
// scenarios and a default 16x16/LANES=4 instance for the full-size drain.
module tb_tc_psum_drain;

    localparam int M = 4, N = 4, DW = 8, DP = 4, L = 2;
    localparam int LW = L * DW;
    localparam int DWM = M * N * DW;
    localparam int BM = 16, BN = 16, BDW = 32, BL = 4;
    localparam int BLW = BL * BDW;
    localparam int BDWM = BM * BN * BDW;

    localparam logic [15:0] HAND [0:7] = '{16'h0100, 16'h0302, 16'h1110, 16'h1312,
                                          16'h2120, 16'h2322, 16'h3130, 16'h3332};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             start, mat_req, mat_valid, o_valid, o_ready, o_last, busy, done;
    logic [DWM-1:0]   mat_in, fill_pat, alt_pat;
    logic [LW-1:0]    o_data;
    logic [DP-1:0]    o_row, o_col;

    logic             b_start, b_mat_req, b_mat_valid, b_o_valid, b_o_ready, b_o_last, b_busy, b_done;
    logic [BDWM-1:0]  b_mat_in;
    logic [BLW-1:0]   b_o_data;
    logic [3:0]       b_o_row, b_o_col;

    tc_psum_drain #(.M(M), .N(N), .DW_DATA(DW), .DW_POS(DP), .LANES(L)) dut (
        .clk(clk), .rst(rst), .start(start), .mat_req(mat_req), .mat_valid(mat_valid),
        .mat_in(mat_in), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
        .o_row(o_row), .o_col(o_col), .o_last(o_last), .busy(busy), .done(done)
    );

    tc_psum_drain dut_big (
        .clk(clk), .rst(rst), .start(b_start), .mat_req(b_mat_req), .mat_valid(b_mat_valid),
        .mat_in(b_mat_in), .o_valid(b_o_valid), .o_ready(b_o_ready), .o_data(b_o_data),
        .o_row(b_o_row), .o_col(b_o_col), .o_last(b_o_last), .busy(b_busy), .done(b_done)
    );

    typedef struct { logic [LW-1:0] data; logic [3:0] row; logic [3:0] col; logic last; } beat_t;
    typedef struct { logic [BLW-1:0] data; logic [3:0] row; logic [3:0] col; logic last; } bbeat_t;

    beat_t  exp_q[$];
    bbeat_t bexp_q[$];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, first_cyc = 0, last_cyc = 0, done_cnt = 0;
    int b_first_cyc = 0, b_done_cyc = 0, b_done_cnt = 0;
    bit bp_mode = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    task automatic push_beats(input int count);
        beat_t b;
        for (int i = 0; i < count; i++) begin
            b.data = HAND[i];
            b.row  = 4'(i / 2);
            b.col  = 4'((i % 2) * 2);
            b.last = (i == 7);
            exp_q.push_back(b);
        end
    endtask

    function automatic logic [31:0] belem(input int r, input int c);
        return {8'hC0, 8'(r), 8'h5A, 8'(c)};
    endfunction

    // Backpressure pattern 1,0,0,1 repeating; otherwise always ready.
    initial begin
        int ph = 0;
        logic [3:0] pat = 4'b1001;
        o_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                o_ready = pat[3 - ph];
                ph = (ph + 1) % 4;
            end else begin
                o_ready = 1'b1;
                ph = 0;
            end
        end
    end

    // Small-instance monitor: scoreboard pop, hold-under-stall, done timing.
    logic           stall_prev = 1'b0, prev_done = 1'b0;
    logic [LW+8:0]  prev_out = '0;
    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (rst) begin
            stall_prev = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (stall_prev && o_valid)
                check("hold_under_stall", 128'({o_data, o_row, o_col, o_last}), 128'(prev_out));
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got row %0d col %0d data %0h, expected none", o_row, o_col, o_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 128'(o_data), 128'(e.data));
                    check("beat_row",  128'(o_row),  128'(e.row));
                    check("beat_col",  128'(o_col),  128'(e.col));
                    check("beat_last", 128'(o_last), 128'(e.last));
                    if (e.row == 0 && e.col == 0) first_cyc = cyc;
                    if (e.last) last_cyc = cyc;
                end
            end
            if (done) begin
                done_cnt++;
                check("done_after_last", 128'(cyc), 128'(last_cyc + 1));
                check("done_one_cycle", 128'(prev_done), 128'(0));
            end
            stall_prev = o_valid && !o_ready;
            prev_out   = {o_data, o_row, o_col, o_last};
            prev_done  = done;
        end
    end

    // Default-size instance monitor.
    always @(negedge clk) begin
        bbeat_t e;
        if (!rst) begin
            if (b_o_valid && b_o_ready) begin
                if (bexp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL big_unexpected_beat: got row %0d col %0d, expected none", b_o_row, b_o_col);
                end else begin
                    e = bexp_q.pop_front();
                    check("big_data", b_o_data, e.data);
                    check("big_row_col_last", 128'({b_o_row, b_o_col, b_o_last}), 128'({e.row, e.col, e.last}));
                    if (e.row == 0 && e.col == 0) b_first_cyc = cyc;
                end
            end
            if (b_done) begin
                b_done_cnt++;
                b_done_cyc = cyc;
            end
        end
    end

    task automatic start_and_capture(input int delay);
        int req_cyc = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i <= delay; i++) begin
            if (i == delay) mat_valid = 1'b1;
            @(negedge clk);
            if (mat_req) req_cyc++;
            check("no_valid_in_req", 128'(o_valid), 128'(0));
            @(posedge clk); #1;
        end
        mat_valid = 1'b0;
        check("req_cycles", 128'(req_cyc), 128'(delay + 1));
    endtask

    task automatic run_drain(input int delay, input bit disturb, input bit bp);
        int d0 = done_cnt;
        bp_mode = bp;
        push_beats(8);
        start_and_capture(delay);
        for (int c = 0; c < 300 && done_cnt == d0; c++) begin
            @(posedge clk); #1;
            if (disturb && c == 2) begin
                mat_in = alt_pat; mat_valid = 1'b1; start = 1'b1;
            end
            if (disturb && c == 5) begin
                mat_in = fill_pat; mat_valid = 1'b0; start = 1'b0;
            end
        end
        if (done_cnt == d0) timeout_fail("wait_done");
        check("queue_empty", 128'(exp_q.size()), 128'(0));
        if (!bp) check("consecutive_beats", 128'(last_cyc - first_cyc), 128'(7));
        @(negedge clk);
        check("idle_after_done", 128'(busy), 128'(0));
        bp_mode = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("single_done", 128'(done_cnt), 128'(d0 + 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bbeat_t bb;
        int d0;
        bit found;
        rst = 1'b1;
        start = 1'b0; mat_valid = 1'b0;
        b_start = 1'b0; b_mat_valid = 1'b0; b_o_ready = 1'b1;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++) begin
                fill_pat[(r*N + c)*DW +: DW] = 8'(r * 16 + c);
                alt_pat[(r*N + c)*DW +: DW]  = 8'hEE;
            end
        for (int r = 0; r < BM; r++)
            for (int c = 0; c < BN; c++)
                b_mat_in[(r*BN + c)*BDW +: BDW] = belem(r, c);
        mat_in = fill_pat;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", 128'({o_valid, mat_req, busy, done, o_last}), 128'(0));
        check("rst_data_pos", 128'({o_data, o_row, o_col}), 128'(0));
        check("rst_big", 128'({b_o_valid, b_mat_req, b_busy, b_done, b_o_data}), 128'(0));
        @(posedge clk); #1 rst = 1'b0;

        run_drain(0, 1'b0, 1'b0);
        run_drain(0, 1'b0, 1'b1);
        run_drain(5, 1'b0, 1'b0);
        run_drain(0, 1'b1, 1'b0);

        // Reset in the middle of a drain, right after beat 3 is accepted.
        d0 = done_cnt;
        push_beats(4);
        start_and_capture(0);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (o_valid && o_ready && o_row == 4'd1 && o_col == 4'd2) found = 1'b1;
        end
        if (!found) timeout_fail("wait_beat3");
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("rst_mid_valid_busy", 128'({o_valid, busy, mat_req}), 128'(0));
        check("rst_mid_data", 128'({o_data, o_row, o_col}), 128'(0));
        check("rst_mid_queue", 128'(exp_q.size()), 128'(0));
        @(posedge clk); #1 rst = 1'b0;
        check("rst_mid_no_done", 128'(done_cnt), 128'(d0));
        run_drain(0, 1'b0, 1'b0);

        // Default-size drain: 64 beats, o_ready high, mat_valid held high.
        for (int i = 0; i < 64; i++) begin
            bb.row = 4'(i / 4);
            bb.col = 4'((i % 4) * 4);
            bb.last = (i == 63);
            for (int k = 0; k < 4; k++) bb.data[k*32 +: 32] = belem(i / 4, (i % 4) * 4 + k);
            bexp_q.push_back(bb);
        end
        b_mat_valid = 1'b1;
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        for (int c = 0; c < 200 && b_done_cnt == 0; c++) @(posedge clk);
        if (b_done_cnt == 0) timeout_fail("big_wait_done");
        check("big_queue_empty", 128'(bexp_q.size()), 128'(0));
        check("big_done_offset", 128'(b_done_cyc - b_first_cyc), 128'(64));
        @(negedge clk);
        @(negedge clk);
        check("big_idle", 128'({b_busy, b_done_cnt}), 128'({1'b0, 32'd1}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
